fetch_sequencer: RTL and testbench

Multicycle controller that sequences the instruction-fetch datapath: PC register, PC+4/branch-target select, and instruction-memory access. It issues word-aligned fetches and captures the returned word into an instruction register. The word is offered downstream with a valid/ready handshake. Branch redirects are applied at a defined point, and in-flight fetches are squashed. Sits between the instruction ROM and decode.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/next_pc_unit.sv | 32 +++
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch sequencer.
// Holds the FSM state encoding and the ROM address range check.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_FAULT
    } state_t;

    localparam int INSTR_BYTES = 4;
    localparam int WORD_LSB    = 2;

    // True when addr is word aligned and inside the implemented ROM.
    function automatic logic in_range(
        input logic [63:0] addr,
        input int unsigned words
    );
        logic [63:0] limit;
        limit = 64'(words) * 64'(INSTR_BYTES);
        return (addr[WORD_LSB-1:0] == '0) && (addr < limit);
    endfunction

endpackage

// File: rtl/next_pc_unit.sv
// Next-PC selection: sequential increment or branch redirect.
// Flags any candidate address that is misaligned, past the ROM or wrapped.
module next_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROM_WORDS  = 16
) (
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] next_pc,
    output logic                  next_fault
);

    logic [DATA_WIDTH:0] seq_sum;

    // Pick the candidate address and range-check it; a carry out is a wrap.
    always_comb begin
        seq_sum    = {1'b0, pc} + (DATA_WIDTH+1)'(INSTR_BYTES);
        next_pc    = seq_sum[DATA_WIDTH-1:0];
        next_fault = 1'b0;
        if (branch_taken) begin
            next_pc    = branch_target;
            next_fault = !in_range(64'(branch_target), ROM_WORDS);
        end else begin
            next_fault = seq_sum[DATA_WIDTH]
                       | !in_range(64'(seq_sum[DATA_WIDTH-1:0]), ROM_WORDS);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle instruction-fetch controller between the ROM and decode.
// Issues word fetches, presents words with valid/ready, handles redirects.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned          MEM_LATENCY = 0,
    parameter int unsigned          ROM_WORDS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] fault_pc
);

    localparam logic [1:0] LAT      = 2'(MEM_LATENCY);
    localparam bit         ZERO_LAT = (MEM_LATENCY == 0);

    state_t                state;
    logic [DATA_WIDTH-1:0] pc;
    logic [1:0]            cnt;
    logic                  squash;
    logic [DATA_WIDTH-1:0] nxt_pc;
    logic                  nxt_fault;

    assign imem_addr = pc;

    next_pc_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROM_WORDS  (ROM_WORDS)
    ) u_next_pc (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (nxt_pc),
        .next_fault    (nxt_fault)
    );

    // Fetch FSM: owns pc, latency counter, squash flag and all outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            cnt         <= '0;
            squash      <= 1'b0;
            imem_req    <= 1'b0;
            instr       <= '0;
            pc_out      <= RESET_PC;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            fault_pc    <= '0;
        end else begin
            imem_req <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (branch_taken && nxt_fault) begin
                        state    <= S_FAULT;
                        fault    <= 1'b1;
                        fault_pc <= nxt_pc;
                    end else begin
                        if (branch_taken) pc <= nxt_pc;
                        if (en) begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (branch_taken) begin
                        if (nxt_fault) begin
                            state    <= S_FAULT;
                            fault    <= 1'b1;
                            fault_pc <= nxt_pc;
                        end else begin
                            pc <= nxt_pc;
                            if (ZERO_LAT) begin
                                state    <= en ? S_REQ : S_IDLE;
                                imem_req <= en;
                            end else begin
                                squash <= 1'b1;
                                cnt    <= LAT;
                                state  <= S_WAIT;
                            end
                        end
                    end else if (ZERO_LAT) begin
                        instr       <= imem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        state       <= S_VALID;
                    end else begin
                        cnt   <= LAT;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (branch_taken && nxt_fault) begin
                        state    <= S_FAULT;
                        fault    <= 1'b1;
                        fault_pc <= nxt_pc;
                    end else begin
                        if (branch_taken) pc <= nxt_pc;
                        if (cnt == 2'd1) begin
                            if (squash || branch_taken) begin
                                squash   <= 1'b0;
                                state    <= en ? S_REQ : S_IDLE;
                                imem_req <= en;
                            end else begin
                                instr       <= imem_rdata;
                                pc_out      <= pc;
                                instr_valid <= 1'b1;
                                state       <= S_VALID;
                            end
                        end else if (branch_taken) begin
                            squash <= 1'b1;
                        end
                    end
                end
                S_VALID: begin
                    if (instr_ready || branch_taken) begin
                        instr_valid <= 1'b0;
                        if (nxt_fault) begin
                            state    <= S_FAULT;
                            fault    <= 1'b1;
                            fault_pc <= nxt_pc;
                        end else begin
                            pc       <= nxt_pc;
                            state    <= en ? S_REQ : S_IDLE;
                            imem_req <= en;
                        end
                    end
                end
                S_FAULT: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer at latencies 0, 2 and 3.
// Directed scenarios plus randomized traffic against a presentation model.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        en     [3];
    logic        rdy    [3];
    logic        br     [3];
    logic [31:0] tgt    [3];
    logic        req    [3];
    logic [31:0] addr   [3];
    logic [31:0] rdata  [3];
    logic [31:0] instr  [3];
    logic [31:0] pco    [3];
    logic        vld    [3];
    logic        flt    [3];
    logic [31:0] fpc    [3];
    logic [31:0] rom    [16];

    int n_tests;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int unsigned LAT = (k == 0) ? 0 : (k == 1) ? 2 : 3;
        assign rdata[k] = rom[addr[k][5:2]];
        fetch_sequencer #(
            .DATA_WIDTH  (32),
            .RESET_PC    (32'h0),
            .MEM_LATENCY (LAT),
            .ROM_WORDS   (16)
        ) u_dut (
            .clk           (clk),
            .reset         (rst),
            .en            (en[k]),
            .imem_req      (req[k]),
            .imem_addr     (addr[k]),
            .imem_rdata    (rdata[k]),
            .instr         (instr[k]),
            .pc_out        (pco[k]),
            .instr_valid   (vld[k]),
            .instr_ready   (rdy[k]),
            .branch_taken  (br[k]),
            .branch_target (tgt[k]),
            .fault         (flt[k]),
            .fault_pc      (fpc[k])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset(input bit check);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en[k] = 0; rdy[k] = 0; br[k] = 0; tgt[k] = '0;
        end
        step();
        step();
        if (check) begin
            for (int k = 0; k < 3; k++) begin
                chk("rst_instr", instr[k], 32'h0);
                chk("rst_pcout", pco[k], 32'h0);
                chk("rst_valid", 32'(vld[k]), 32'h0);
                chk("rst_req", 32'(req[k]), 32'h0);
                chk("rst_fault", 32'(flt[k]), 32'h0);
                chk("rst_fpc", fpc[k], 32'h0);
                chk("rst_addr", addr[k], 32'h0);
            end
        end
        rst = 1'b0;
    endtask

    task automatic wait_vld(input int k, input int maxc, output int cyc);
        cyc = 0;
        do begin
            step();
            br[k] = 1'b0;
            cyc++;
        end while (!vld[k] && cyc < maxc);
        if (!vld[k]) chk("timeout_valid", 32'(vld[k]), 32'h1);
    endtask

    task automatic run_random(input int k, input int ncyc);
        logic [31:0] exp;
        int          since;
        bit          prev_v;
        do_reset(1'b0);
        en[k]  = 1'b1;
        exp    = 32'h0;
        since  = -1;
        prev_v = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            if (vld[k]) begin
                chk("rnd_pc", pco[k], exp);
                chk("rnd_instr", instr[k], rom[exp[5:2]]);
                if (!prev_v && since >= 0)
                    chk("rnd_gap", 32'(since), 32'(lat_of(k) + 2));
            end
            chk("rnd_nofault", 32'(flt[k]), 32'h0);
            prev_v = vld[k];
            rdy[k] = ($urandom % 4) != 0;
            br[k]  = ($urandom % 6) == 0;
            tgt[k] = ($urandom % 16) << 2;
            if (vld[k] && rdy[k] && !br[k] && exp == 32'h3C) br[k] = 1'b1;
            if (br[k]) begin
                exp   = tgt[k];
                since = -1;
            end else if (vld[k] && rdy[k]) begin
                exp   = exp + 32'd4;
                since = 0;
            end
            step();
            if (since >= 0) since++;
        end
        br[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        logic [31:0] exp_pc [4];
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 16; i++) rom[i] = 32'hA500_0000 + 32'(i);
        rom[0] = 32'h0;
        rom[1] = 32'hE3A02005;
        rom[2] = 32'hE3A03004;
        rom[3] = 32'hE0824003;
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};

        // 1: sequential stream at L=0
        do_reset(1'b1);
        en[0] = 1; rdy[0] = 1;
        for (int i = 0; i < 4; i++) begin
            wait_vld(0, 10, c);
            chk("t1_gap", 32'(c), 32'd2);
            chk("t1_pc", pco[0], exp_pc[i]);
            chk("t1_instr", instr[0], rom[i]);
        end

        // 2: backpressure holds the word
        do_reset(1'b0);
        en[0] = 1; rdy[0] = 1;
        wait_vld(0, 10, c);
        wait_vld(0, 10, c);
        rdy[0] = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_valid", 32'(vld[0]), 32'h1);
            chk("t2_instr", instr[0], 32'hE3A02005);
            chk("t2_pc", pco[0], 32'h4);
            chk("t2_noreq", 32'(req[0]), 32'h0);
        end
        rdy[0] = 1;
        wait_vld(0, 10, c);
        chk("t2_next_pc", pco[0], 32'h8);
        chk("t2_next_instr", instr[0], 32'hE3A03004);

        // 3: branch on handshake
        do_reset(1'b0);
        en[0] = 1; rdy[0] = 1;
        wait_vld(0, 10, c);
        wait_vld(0, 10, c);
        br[0] = 1; tgt[0] = 32'hC;
        wait_vld(0, 10, c);
        chk("t3_pc", pco[0], 32'hC);
        chk("t3_instr", instr[0], 32'hE0824003);

        // 4: branch during WAIT at L=2 squashes the fetch
        do_reset(1'b0);
        en[1] = 1; rdy[1] = 1;
        wait_vld(1, 10, c);
        wait_vld(1, 10, c);
        step();
        chk("t4_req", 32'(req[1]), 32'h1);
        chk("t4_addr", addr[1], 32'h8);
        step();
        chk("t4_wait_noreq", 32'(req[1]), 32'h0);
        br[1] = 1; tgt[1] = 32'h4;
        wait_vld(1, 20, c);
        chk("t4_gap", 32'(c), 32'd5);
        chk("t4_pc", pco[1], 32'h4);
        chk("t4_instr", instr[1], 32'hE3A02005);

        // 5a: misaligned branch target faults and sticks
        do_reset(1'b0);
        en[0] = 1; rdy[0] = 1;
        wait_vld(0, 10, c);
        br[0] = 1; tgt[0] = 32'h6;
        step();
        br[0] = 0;
        chk("t5_fault", 32'(flt[0]), 32'h1);
        chk("t5_fpc", fpc[0], 32'h6);
        chk("t5_addr", addr[0], 32'h0);
        for (int i = 0; i < 20; i++) begin
            en[0]  = 1'($urandom);
            rdy[0] = 1'($urandom);
            br[0]  = 1'($urandom);
            tgt[0] = ($urandom % 16) << 2;
            step();
            chk("t5_sticky", 32'(flt[0]), 32'h1);
            chk("t5_sticky_fpc", fpc[0], 32'h6);
            chk("t5_novalid", 32'(vld[0]), 32'h0);
            chk("t5_noreq", 32'(req[0]), 32'h0);
        end

        // 5b: sequential run off the end of the ROM
        do_reset(1'b0);
        en[0] = 1; rdy[0] = 1;
        for (int i = 0; i < 16; i++) wait_vld(0, 10, c);
        chk("t5b_last_pc", pco[0], 32'h3C);
        step();
        chk("t5b_fault", 32'(flt[0]), 32'h1);
        chk("t5b_fpc", fpc[0], 32'h40);
        chk("t5b_novalid", 32'(vld[0]), 32'h0);
        chk("t5b_pc_held", addr[0], 32'h3C);

        // 6: reset mid-WAIT at L=3
        do_reset(1'b0);
        en[2] = 1; rdy[2] = 1;
        wait_vld(2, 20, c);
        chk("t6_first_gap", 32'(c), 32'd5);
        step();
        step();
        chk("t6_addr_before", addr[2], 32'h4);
        rst = 1'b1;
        step();
        chk("t6_rst_addr", addr[2], 32'h0);
        chk("t6_rst_pc", pco[2], 32'h0);
        chk("t6_rst_instr", instr[2], 32'h0);
        chk("t6_rst_valid", 32'(vld[2]), 32'h0);
        chk("t6_rst_req", 32'(req[2]), 32'h0);
        rst = 1'b0;
        wait_vld(2, 20, c);
        chk("t6_restart_gap", 32'(c), 32'd5);
        chk("t6_restart_pc", pco[2], 32'h0);

        // Randomized traffic on every latency
        for (int k = 0; k < 3; k++) run_random(k, 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
